// File: rtl/divider_pkg.sv
// Shared definitions for the signed restoring divider: default width,
// controller state encoding and iteration bookkeeping constants.
package divider_pkg;

  // Default operand/result width; also the number of shift-subtract
  // iterations a full-width division takes.
  localparam int WIDTH_DEFAULT = 32;
  localparam int ITER_COUNT    = WIDTH_DEFAULT;

  // Width of the iteration counter (enough for widths up to 63).
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/divider_div_step.sv
// One radix-2 restoring iteration on unsigned magnitudes. The working
// register holds the partial remainder in the upper half and the
// dividend/quotient bits in the lower half.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] work,
  input  logic [WIDTH-1:0]   divisor_mag,
  output logic [2*WIDTH-1:0] work_next
);

  // The partial remainder after the shift needs one extra bit: with a
  // divisor magnitude above 2^(WIDTH-1) the shifted value can exceed WIDTH bits.
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           q_bit;

  // Shift left, trial-subtract, restore on borrow, quotient bit into LSB.
  always_comb begin
    trial     = work[2*WIDTH-1:WIDTH-1];
    diff      = trial - {1'b0, divisor_mag};
    q_bit     = (trial >= {1'b0, divisor_mag});
    work_next = {2*WIDTH{1'b0}};
    if (q_bit) begin
      work_next[2*WIDTH-1:WIDTH] = diff[WIDTH-1:0];
    end else begin
      work_next[2*WIDTH-1:WIDTH] = trial[WIDTH-1:0];
    end
    work_next[WIDTH-1:0] = {work[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/divider.sv
// Signed multicycle divider: magnitudes are divided one bit per clock by
// div_step, then signs are applied in a single fix-up cycle. Quotient
// truncates toward zero and the remainder takes the sign of the dividend.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   count_reg;
  logic [2*WIDTH-1:0] work_reg;
  logic [2*WIDTH-1:0] work_step;
  logic [WIDTH-1:0]   dmag_reg;
  logic               dvd_neg_reg;
  logic               dvs_neg_reg;
  logic               dz_reg;

  logic [WIDTH-1:0]   dividend_mag;
  logic [WIDTH-1:0]   divisor_mag;
  logic [WIDTH-1:0]   low_half;
  logic [WIDTH-1:0]   high_half;
  logic [WIDTH-1:0]   rem_src;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1),
  // which is still representable as an unsigned magnitude.
  always_comb begin
    dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    low_half     = work_reg[WIDTH-1:0];
    high_half    = work_reg[2*WIDTH-1:WIDTH];
    // A zero divisor skips every iteration, so the untouched low half
    // still holds |dividend| and becomes the remainder magnitude.
    rem_src      = dz_reg ? low_half : high_half;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .work       (work_reg),
    .divisor_mag(dmag_reg),
    .work_next  (work_step)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a zero divisor bypasses RUN entirely.
  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        if (count_reg == LAST_ITER) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result fix-up with done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg   <= '0;
      work_reg    <= '0;
      dmag_reg    <= '0;
      dvd_neg_reg <= 1'b0;
      dvs_neg_reg <= 1'b0;
      dz_reg      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            work_reg    <= {{WIDTH{1'b0}}, dividend_mag};
            dmag_reg    <= divisor_mag;
            dvd_neg_reg <= dividend[WIDTH-1];
            dvs_neg_reg <= divisor[WIDTH-1];
            dz_reg      <= (divisor == '0);
            count_reg   <= '0;
            if (divisor != '0) begin
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          work_reg  <= work_step;
          count_reg <= count_reg + 1'b1;
        end
        FIX: begin
          if (dz_reg) begin
            quotient <= '1;
          end else if (dvd_neg_reg ^ dvs_neg_reg) begin
            quotient <= ~low_half + 1'b1;
          end else begin
            quotient <= low_half;
          end
          remainder   <= dvd_neg_reg ? (~rem_src + 1'b1) : rem_src;
          div_by_zero <= dz_reg;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: the driver pushes hand-computed results,
// a monitor pops and compares whenever done pulses.
module tb_divider;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           t0;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_quotient"}, quotient, e.q);
        check({e.name, "_remainder"}, remainder, e.r);
        check({e.name, "_dz"}, {31'd0, div_by_zero}, {31'd0, e.dz});
        check({e.name, "_latency"}, W'(cyc - e.t0), W'(e.lat));
        $display("op %s: q=0x%08h r=0x%08h dz=%0b latency=%0d", e.name, quotient, remainder,
                 div_by_zero, cyc - e.t0);
      end
    end
  end

  // Called at a negedge: drive start for one cycle, push the expectation,
  // then return at the negedge where done is seen (so a following call
  // issues a back-to-back start).
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    exp_t e;
    bit   seen;
    e.name = name; e.q = q; e.r = r; e.dz = dz;
    e.t0   = cyc + 1;
    e.lat  = dz ? 1 : W + 1;
    exp_q.push_back(e);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    if (b != '0) check({name, "_dz_cleared"}, {31'd0, div_by_zero}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end else begin
      check({name, "_idle_at_done"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;

    run_op("100/7",    32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    run_op("-100/7",   32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0);
    run_op("100/-7",   32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0);
    run_op("-100/-7",  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0);
    run_op("100/0",    32'd100,        32'd0,          32'hFFFFFFFF,   32'd100,        1'b1);
    run_op("-100/0",   32'hFFFFFF9C,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF9C,   1'b1);
    run_op("min/-1",   32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
    run_op("min/min",  32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0);
    run_op("5/min",    32'd5,          32'h80000000,   32'd0,          32'd5,          1'b0);
    run_op("7/100",    32'd7,          32'd100,        32'd0,          32'd7,          1'b0);
    run_op("max/1",    32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0,          1'b0);
    run_op("1000/-33", 32'd1000,       32'hFFFFFFDF,   32'hFFFFFFE2,   32'd10,         1'b0);
    @(negedge clk);

    // Second start during RUN must be ignored entirely.
    begin
      exp_t e;
      e.name = "ignored_restart"; e.q = 32'd14; e.r = 32'd2; e.dz = 1'b0;
      e.t0 = cyc + 1; e.lat = W + 1;
      exp_q.push_back(e);
      start = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      @(negedge clk);
      start = 1'b0; dividend = '0; divisor = '0;
      repeat (30) @(negedge clk);
    end

    // Reset mid-run: outputs clear immediately and no done follows.
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_quotient", quotient, '0);
    check("midreset_remainder", remainder, '0);
    check("midreset_dz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_op("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    repeat (40) @(negedge clk);

    check("scoreboard_drained", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
